synth_bank: RTL and testbench

- Parametrised additive-synthesis engine that builds one waveform frame of 2^N_LOG2 samples in an internal signed accumulator buffer.
- Each accepted partial (magnitude, frequency, phase) is swept across the whole frame. Each sample gets mag·sin(phase + 2π·freq·x/N) added to it.
- A host-side controller streams partials in through a valid/ready handshake, then reads the frame out sample by sample through a registered read port.
- Compared with the single-partial synth, it adds handshaking, frame clear, a saturating wide accumulator and an automatic clear after reset.

---
 rtl/synth_bank.sv | 180 ++++++++++++++++++
 tb/tb_synth_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_bank.sv
// Additive-synthesis frame engine: partials stream in over valid/ready and are
// swept across a 2^N_LOG2-sample signed accumulator frame, then read back clipped.
module synth_bank #(
  parameter int N_LOG2   = 11,
  parameter int MAG_W    = 16,
  parameter int PH_W     = 16,
  parameter int LUT_LOG2 = 10,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              part_valid,
  output logic              part_ready,
  input  logic [MAG_W-1:0]  magnitude,
  input  logic [N_LOG2-1:0] frequency,
  input  logic [PH_W-1:0]   phase,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  input  logic [N_LOG2-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              rd_valid
);

  localparam int N        = 1 << N_LOG2;
  localparam int LUT_N    = 1 << LUT_LOG2;
  localparam int SIN_W    = 16;
  localparam int PROD_W   = MAG_W + 1;
  localparam int FULL_W   = PROD_W + SIN_W;
  localparam int PH_SHIFT = PH_W - N_LOG2;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  // Q1.15 sine table, evaluated at elaboration time.
  function automatic logic signed [SIN_W-1:0] sine_entry(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N));
    return SIN_W'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  logic signed [SIN_W-1:0] sine_rom [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    assign sine_rom[k] = sine_entry(k);
  end

  logic signed [ACC_W-1:0] frame_buf [N];

  state_t                   state;
  logic [N_LOG2-1:0]        x;
  logic [PH_W-1:0]          ph;
  logic [MAG_W-1:0]         mag_q;
  logic [N_LOG2-1:0]        freq_q;
  logic [1:0]               drain_cnt;
  logic                     s1_valid, s2_valid;
  logic [N_LOG2-1:0]        s1_addr, s2_addr;
  logic signed [SIN_W-1:0]  s1_sin;
  logic signed [PROD_W-1:0] s2_prod;

  logic signed [FULL_W-1:0] full_prod;
  logic signed [PROD_W-1:0] prod_next;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W-1:0]  acc_sat;
  logic signed [ACC_W-1:0]  rd_word;
  logic [OUT_W-1:0]         rd_sat;
  logic                     buf_we;
  logic [N_LOG2-1:0]        buf_waddr;
  logic signed [ACC_W-1:0]  buf_wdata;

  assign part_ready = (state == IDLE) && !clr;
  assign busy       = (state == CLEAR) || (state == ACCUM);

  assign full_prod = $signed({1'b0, mag_q}) * s1_sin;
  assign prod_next = PROD_W'(full_prod >>> (SIN_W - 1));

  // Read-modify-write of the frame; addresses never repeat inside one sweep.
  assign acc_sum = (ACC_W+1)'(frame_buf[s2_addr]) + (ACC_W+1)'(s2_prod);
  assign acc_sat = (acc_sum[ACC_W] != acc_sum[ACC_W-1])
                 ? {acc_sum[ACC_W], {(ACC_W-1){~acc_sum[ACC_W]}}}
                 : acc_sum[ACC_W-1:0];

  assign rd_word = frame_buf[rd_addr];
  assign rd_sat  = (&rd_word[ACC_W-1:OUT_W-1] || ~|rd_word[ACC_W-1:OUT_W-1])
                 ? rd_word[OUT_W-1:0]
                 : {rd_word[ACC_W-1], {(OUT_W-1){~rd_word[ACC_W-1]}}};

  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = x;
    buf_wdata = '0;
    if (state == CLEAR) begin
      buf_we = 1'b1;
    end else if (s2_valid) begin
      buf_we    = 1'b1;
      buf_waddr = s2_addr;
      buf_wdata = acc_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) frame_buf[buf_waddr] <= buf_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      x         <= '0;
      ph        <= '0;
      mag_q     <= '0;
      freq_q    <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_sin    <= '0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_prod   <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_prod  <= prod_next;

      if (state == IDLE && rd_en) begin
        rd_valid <= 1'b1;
        rd_data  <= rd_sat;
      end else begin
        rd_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            x     <= '0;
          end else if (part_valid) begin
            mag_q  <= magnitude;
            freq_q <= frequency;
            ph     <= phase;
            x      <= '0;
            state  <= ACCUM;
          end
        end
        CLEAR: begin
          x <= x + 1'b1;
          if (&x) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        ACCUM: begin
          s1_valid <= 1'b1;
          s1_addr  <= x;
          s1_sin   <= sine_rom[ph[PH_W-1 -: LUT_LOG2]];
          ph       <= ph + (PH_W'(freq_q) << PH_SHIFT);
          x        <= x + 1'b1;
          if (&x) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_bank.sv
// Randomized self-checking bench for synth_bank against a per-sample
// mag*sin(phase + 2*pi*freq*x/N) reference frame.
module tb_synth_bank;

  localparam int  N      = 2048;
  localparam int  LUT_N  = 1024;
  localparam int  TURN   = 65536;
  localparam real PI     = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        part_valid = 1'b0;
  logic        part_ready;
  logic [15:0] magnitude = '0;
  logic [10:0] frequency = '0;
  logic [15:0] phase = '0;
  logic        clr = 1'b0;
  logic        busy;
  logic        done;
  logic        rd_en = 1'b0;
  logic [10:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;

  int     checks = 0;
  int     errors = 0;
  int     lut_tb [LUT_N];
  longint model [N];

  synth_bank dut (
    .clk(clk), .rst_n(rst_n),
    .part_valid(part_valid), .part_ready(part_ready),
    .magnitude(magnitude), .frequency(frequency), .phase(phase),
    .clr(clr), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic longint clip(longint v, longint lo, longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic longint floorDiv(longint p, longint d);
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  // Adds one partial to every sample of the reference frame.
  function automatic void modelAdd(int mag, int freq, int ph0);
    for (int xi = 0; xi < N; xi++) begin
      longint angle = (longint'(ph0) + longint'(freq) * xi * (TURN / N)) % TURN;
      int     idx   = int'(angle * LUT_N / TURN);
      longint prod  = floorDiv(longint'(mag) * lut_tb[idx], 32768);
      model[xi] = clip(model[xi] + prod, -(64'sd1 << 23), (64'sd1 << 23) - 1);
    end
  endfunction

  function automatic void modelClear();
    for (int xi = 0; xi < N; xi++) model[xi] = 0;
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int limit, input int clr_at, output int n);
    n = 0;
    do begin
      if (n == clr_at) clr = 1'b1;
      tick();
      clr = 1'b0;
      n++;
    end while (!done && n < limit);
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic readSample(input int addr, output longint val);
    rd_en   = 1'b1;
    rd_addr = 11'(addr);
    tick();
    rd_en = 1'b0;
    checkOutput("rd_valid", longint'(rd_valid), 1);
    val = longint'($signed(rd_data));
    checkOutput($sformatf("rd[%0d]", addr), val, clip(model[addr], -32768, 32767));
  endtask

  task automatic applyStimulus(input int mag, input int freq, input int ph0, input int clr_at);
    int n, w;
    part_valid = 1'b1;
    magnitude  = 16'(mag);
    frequency  = 11'(freq);
    phase      = 16'(ph0);
    w = 0;
    while (!part_ready && w < 100) begin
      tick();
      w++;
    end
    checkOutput("part_ready", longint'(part_ready), 1);
    tick();
    part_valid = 1'b0;
    modelAdd(mag, freq, ph0);
    waitDone(2100, clr_at, n);
    checkOutput("accum_cycles", n, 2051);
  endtask

  task automatic clearFrame();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    modelClear();
    waitDone(2100, -1, n);
    checkOutput("clear_cycles", n, 2048);
  endtask

  // Asynchronous reset mid-cycle, then the automatic clear with reads attempted.
  task automatic resetDut();
    int n;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", longint'(busy), 1);
    checkOutput("rst_part_ready", longint'(part_ready), 0);
    checkOutput("rst_done", longint'(done), 0);
    checkOutput("rst_rd_valid", longint'(rd_valid), 0);
    checkOutput("rst_rd_data", longint'(rd_data), 0);
    tick();
    tick();
    rst_n   = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 11'd3;
    modelClear();
    n = 0;
    do begin
      tick();
      n++;
      if (n <= 3) checkOutput("rd_valid_in_clear", longint'(rd_valid), 0);
      if (n == 3) rd_en = 1'b0;
      if (n == 1000) checkOutput("part_ready_in_clear", longint'(part_ready), 0);
    end while (busy && n < 2100);
    checkOutput("reset_clear_cycles", n, 2048);
    checkOutput("reset_clear_done", longint'(done), 1);
    tick();
    checkOutput("done_one_cycle", longint'(done), 0);
  endtask

  initial begin
    longint v;
    int     n;
    int     mag, freq, ph0, addr;

    for (int k = 0; k < LUT_N; k++) begin
      real s;
      s = 32767.0 * $sin(2.0 * PI * real'(k) / real'(LUT_N));
      lut_tb[k] = int'($floor(s + 0.5));
    end
    modelClear();

    resetDut();
    readSample(0, v);    checkOutput("clr_rd0", v, 0);
    readSample(1000, v); checkOutput("clr_rd1000", v, 0);
    readSample(2047, v); checkOutput("clr_rd2047", v, 0);

    applyStimulus(16'h0100, 1, 0, -1);
    readSample(0, v);    checkOutput("p1_rd0", v, 0);
    readSample(512, v);  checkOutput("p1_rd512", v, 16'sh00FF);
    readSample(1024, v); checkOutput("p1_rd1024", v, 0);
    readSample(1536, v); checkOutput("p1_rd1536", v, -256);
    tick();
    checkOutput("rd_valid_drop", longint'(rd_valid), 0);
    checkOutput("rd_hold", longint'($signed(rd_data)), -256);

    applyStimulus(16'h0100, 1, 0, -1);
    readSample(512, v);  checkOutput("p2_rd512", v, 510);
    readSample(1536, v); checkOutput("p2_rd1536", v, -512);

    clearFrame();
    applyStimulus(16'hFFFF, 0, 16'h4000, -1);
    for (int i = 0; i < 6; i++) begin
      readSample((i == 0) ? 0 : (i == 5) ? 2047 : $urandom_range(N - 1, 0), v);
      checkOutput("dc_pos", v, 32767);
    end
    applyStimulus(16'hFFFF, 0, 16'hC000, -1);
    for (int i = 0; i < 6; i++) begin
      readSample((i == 0) ? 0 : (i == 5) ? 2047 : $urandom_range(N - 1, 0), v);
      checkOutput("dc_wide", v, -1);
    end

    mag  = $urandom_range(65535, 0);
    freq = $urandom_range(N - 1, 0);
    ph0  = $urandom_range(TURN - 1, 0);
    clr        = 1'b1;
    part_valid = 1'b1;
    magnitude  = 16'(mag);
    frequency  = 11'(freq);
    phase      = 16'(ph0);
    #1;
    checkOutput("ready_under_clr", longint'(part_ready), 0);
    tick();
    clr = 1'b0;
    checkOutput("busy_after_clr", longint'(busy), 1);
    modelClear();
    waitDone(2100, -1, n);
    checkOutput("clr_pv_cycles", n, 2048);
    checkOutput("ready_after_clear", longint'(part_ready), 1);
    tick();
    part_valid = 1'b0;
    modelAdd(mag, freq, ph0);
    waitDone(2100, -1, n);
    checkOutput("held_partial_cycles", n, 2051);
    for (int i = 0; i < 8; i++) readSample($urandom_range(N - 1, 0), v);

    for (int p = 0; p < 4; p++) begin
      applyStimulus($urandom_range(65535, 0), $urandom_range(N - 1, 0),
                    $urandom_range(TURN - 1, 0), (p == 1) ? 900 : -1);
      for (int i = 0; i < 6; i++) readSample($urandom_range(N - 1, 0), v);
    end

    // Ensure rd_data is nonzero before the mid-sweep reset.
    addr = 0;
    for (int i = 0; i < N; i++) if (clip(model[i], -32768, 32767) != 0) addr = i;
    readSample(addr, v);

    part_valid = 1'b1;
    magnitude  = 16'($urandom_range(65535, 1));
    frequency  = 11'($urandom_range(N - 1, 1));
    phase      = 16'($urandom_range(TURN - 1, 0));
    checkOutput("ready_before_abort", longint'(part_ready), 1);
    tick();
    part_valid = 1'b0;
    repeat (700) tick();
    checkOutput("busy_mid_accum", longint'(busy), 1);
    resetDut();
    readSample(0, v);
    readSample(2047, v);
    for (int i = 0; i < 12; i++) readSample($urandom_range(N - 1, 0), v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
